// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the SEC-DED Hamming(12,8)+P codec.
// Used by both the encoder and decoder sides of the MAC datapath.
package hamming_pkg;

    localparam int DATA_W = 8;
    localparam int CW_W   = 13;
    localparam int SYN_W  = 4;

    // Hamming positions of data bits d0..d7 and parity bits.
    localparam logic [3:0] DPOS [DATA_W] =
        '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};
    localparam logic [3:0] PPOS [SYN_W] =
        '{4'd1, 4'd2, 4'd4, 4'd8};

    localparam logic [SYN_W-1:0] MAX_POS = 4'd12;

    typedef enum logic [1:0] {
        CLS_CLEAN,
        CLS_PAR,
        CLS_FIX,
        CLS_BAD
    } cls_e;

    // XOR of the indices of all set positions 1..12.
    function automatic logic [SYN_W-1:0] syndrome(
        input logic [CW_W-1:0] cw
    );
        logic [SYN_W-1:0] s;
        s = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (cw[k]) s = s ^ SYN_W'(k);
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(
        input logic [CW_W-1:0] cw
    );
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DPOS[i]];
        end
        return d;
    endfunction

    function automatic cls_e classify(
        input logic [SYN_W-1:0] s,
        input logic             p
    );
        cls_e c;
        c = CLS_BAD;
        unique case (1'b1)
            (s == '0) && !p: c = CLS_CLEAN;
            (s == '0) && p:  c = CLS_PAR;
            (s != '0) && p && (s <= MAX_POS):
                c = CLS_FIX;
            default: c = CLS_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hamming_secded_decoder_syndrome_calc.sv
// Combinational syndrome and overall-parity generator.
// Feeds the stage-1 register of the decoder.
module hamming_syndrome_calc
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  code,
    output logic [SYN_W-1:0] syn,
    output logic             par
);

    assign syn = syndrome(code);
    assign par = ^code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage streaming SEC-DED decoder with valid/ready on both sides.
// Corrects single-bit errors and counts corrected/uncorrectable words.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [12:0]       in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [3:0]        out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corrected,
    output logic [CNT_W-1:0]  cnt_uncorrectable
);

    logic              s1_valid;
    logic [CW_W-1:0]   s1_code;
    logic [SYN_W-1:0]  s1_syn;
    logic              s1_par;

    logic [SYN_W-1:0]  syn;
    logic              par;

    logic              load2;
    logic              in_hs;
    logic              out_hs;

    cls_e              cls;
    logic [CW_W-1:0]   fix_mask;
    logic [DATA_W-1:0] fix_data;

    hamming_syndrome_calc u_syn (
        .code (in_code),
        .syn  (syn),
        .par  (par)
    );

    assign load2    = !out_valid || out_ready;
    assign in_ready = !s1_valid || load2;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Classify the stage-1 word and build its corrected data.
    always_comb begin
        cls      = classify(s1_syn, s1_par);
        fix_mask = '0;
        if (cls == CLS_FIX) fix_mask = CW_W'(1) << s1_syn;
        fix_data = extract_data(s1_code ^ fix_mask);
    end

    // Stage 1: capture the raw word with its syndrome and parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_hs) begin
            s1_valid <= 1'b1;
            s1_code  <= in_code;
            s1_syn   <= syn;
            s1_par   <= par;
        end else if (load2) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (load2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data          <= fix_data;
                out_syndrome      <= s1_syn;
                out_corrected     <= (cls == CLS_PAR) ||
                                     (cls == CLS_FIX);
                out_uncorrectable <= (cls == CLS_BAD);
            end
        end
    end

    // Saturating corrected-word counter; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corrected <= '0;
        end else if (clr_cnt) begin
            cnt_corrected <= '0;
        end else if (out_hs && out_corrected &&
                     (cnt_corrected != '1)) begin
            cnt_corrected <= cnt_corrected + CNT_W'(1);
        end
    end

    // Saturating uncorrectable-word counter; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_uncorrectable <= '0;
        end else if (clr_cnt) begin
            cnt_uncorrectable <= '0;
        end else if (out_hs && out_uncorrectable &&
                     (cnt_uncorrectable != '1)) begin
            cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: error-injection model + scoreboard.
// Two instances share stimulus: default CNT_W and CNT_W=2.
module tb_hamming_secded_decoder;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] syn;
        logic       cor;
        logic       unc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [12:0] in_code = '0;
    logic        out_ready = 1'b0;
    logic        clr_cnt = 1'b0;

    logic        a_in_ready, a_out_valid, a_cor, a_unc;
    logic [7:0]  a_data;
    logic [3:0]  a_syn;
    logic [15:0] a_cnt_cor, a_cnt_unc;

    logic        b_in_ready, b_out_valid, b_cor, b_unc;
    logic [7:0]  b_data;
    logic [3:0]  b_syn;
    logic [1:0]  b_cnt_cor, b_cnt_unc;

    int checks = 0;
    int failures = 0;

    exp_t cur_exp;
    exp_t q[$];
    exp_t e;
    int   pops = 0;
    int   mc_a = 0, mu_a = 0, mc_b = 0, mu_b = 0;
    bit   prev_stall = 0;
    exp_t prev_out;

    int dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    always #5 clk = ~clk;

    hamming_secded_decoder #(.CNT_W(16)) dut_a (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (a_in_ready),
        .in_code           (in_code),
        .out_valid         (a_out_valid),
        .out_ready         (out_ready),
        .out_data          (a_data),
        .out_syndrome      (a_syn),
        .out_corrected     (a_cor),
        .out_uncorrectable (a_unc),
        .clr_cnt           (clr_cnt),
        .cnt_corrected     (a_cnt_cor),
        .cnt_uncorrectable (a_cnt_unc)
    );

    hamming_secded_decoder #(.CNT_W(2)) dut_b (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (b_in_ready),
        .in_code           (in_code),
        .out_valid         (b_out_valid),
        .out_ready         (out_ready),
        .out_data          (b_data),
        .out_syndrome      (b_syn),
        .out_corrected     (b_cor),
        .out_uncorrectable (b_unc),
        .clr_cnt           (clr_cnt),
        .cnt_corrected     (b_cnt_cor),
        .cnt_uncorrectable (b_cnt_unc)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, req);
        end
    endtask

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] cw;
        cw = '0;
        for (int i = 0; i < 8; i++) cw[dpos[i]] = d[i];
        for (int j = 0; j < 4; j++) begin
            logic pb;
            pb = 1'b0;
            for (int k = 1; k <= 12; k++)
                if (((k >> j) & 1) == 1) pb = pb ^ cw[k];
            cw[1 << j] = pb;
        end
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    function automatic logic [7:0] extract(input logic [12:0] cw);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = cw[dpos[i]];
        return d;
    endfunction

    // Expected result derived from the injected error mask.
    function automatic exp_t predict(input logic [7:0] d,
                                     input logic [12:0] m);
        exp_t r;
        logic [12:0] rx;
        int s;
        bit p;
        rx = encode(d) ^ m;
        s = 0;
        for (int k = 1; k <= 12; k++) if (m[k]) s = s ^ k;
        p = ($countones(m) % 2) == 1;
        if (s == 0 && !p) begin
            r = '{d, 4'd0, 1'b0, 1'b0};
        end else if (s == 0) begin
            r = '{extract(rx), 4'd0, 1'b1, 1'b0};
        end else if (p && s <= 12) begin
            rx[s] = ~rx[s];
            r = '{extract(rx), 4'(s), 1'b1, 1'b0};
        end else begin
            r = '{extract(rx), 4'(s), 1'b0, 1'b1};
        end
        return r;
    endfunction

    function automatic logic [12:0] rand_mask(input int n);
        logic [12:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, 12)] = 1'b1;
        return m;
    endfunction

    // Scoreboard: checks handshake, order, flags, stalls, counters.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mc_a = 0; mu_a = 0; mc_b = 0; mu_b = 0;
            prev_stall = 0;
        end else begin
            chk("in_ready_a", a_in_ready,
                (q.size() < 2) || out_ready);
            chk("in_ready_b", b_in_ready,
                (q.size() < 2) || out_ready);
            chk("cnt_cor_a", a_cnt_cor, mc_a);
            chk("cnt_unc_a", a_cnt_unc, mu_a);
            chk("cnt_cor_b", b_cnt_cor, mc_b);
            chk("cnt_unc_b", b_cnt_unc, mu_b);
            if (prev_stall) begin
                chk("stall_valid", a_out_valid, 1);
                chk("stall_hold", {a_data, a_syn, a_cor, a_unc},
                    prev_out);
            end
            if (a_out_valid && out_ready) begin
                chk("word_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    pops++;
                    chk("word_a", {a_data, a_syn, a_cor, a_unc}, e);
                    chk("word_b", {b_data, b_syn, b_cor, b_unc}, e);
                    chk("valid_b", b_out_valid, 1);
                    if (e.cor) begin
                        if (mc_a < 65535) mc_a++;
                        if (mc_b < 3) mc_b++;
                    end
                    if (e.unc) begin
                        if (mu_a < 65535) mu_a++;
                        if (mu_b < 3) mu_b++;
                    end
                end
            end
            if (clr_cnt) begin
                mc_a = 0; mu_a = 0; mc_b = 0; mu_b = 0;
            end
            prev_stall = a_out_valid && !out_ready;
            prev_out = '{a_data, a_syn, a_cor, a_unc};
            if (in_valid && a_in_ready) q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [12:0] c, input exp_t x);
        bit got;
        got = 0;
        in_code = c;
        cur_exp = x;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = a_in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accept", got, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  d;
        logic [12:0] m;
        int          p0;
        bit          got;

        chk("pin_encode", encode(8'hA5), 13'h144E);
        chk("pin_model_single", predict(8'hA5, 13'h0040),
            {8'hA5, 4'd6, 1'b1, 1'b0});
        chk("pin_model_double", predict(8'hA5, 13'h0440),
            {8'h81, 4'd12, 1'b0, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_cnt", {a_cnt_cor, a_cnt_unc}, 0);

        // Latency of a clean word.
        out_ready = 1'b1;
        in_code = 13'h144E;
        cur_exp = '{8'hA5, 4'd0, 1'b0, 1'b0};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_cycle1", a_out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", a_out_valid, 1);
        chk("clean_word", {a_data, a_syn, a_cor, a_unc},
            {8'hA5, 4'd0, 1'b0, 1'b0});

        send(13'h140E, '{8'hA5, 4'd6, 1'b1, 1'b0});
        send(13'h144F, '{8'hA5, 4'd0, 1'b1, 1'b0});
        send(13'h100E, '{8'h81, 4'd12, 1'b0, 1'b1});
        idle(4);
        chk("dir_cnt_cor", a_cnt_cor, 2);
        chk("dir_cnt_unc", a_cnt_unc, 1);

        // Downstream stall with three back-to-back words.
        p0 = pops;
        out_ready = 1'b0;
        send(encode(8'h3C), predict(8'h3C, '0));
        send(encode(8'h5A) ^ 13'h0008, predict(8'h5A, 13'h0008));
        in_code = encode(8'hC3);
        cur_exp = predict(8'hC3, '0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", a_in_ready, 0);
            chk("stall_first", a_data, 8'h3C);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = a_in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stall_third_accept", got, 1);
        idle(4);
        chk("stall_all_out", pops - p0, 3);
        chk("stall_queue_empty", q.size(), 0);

        // Counter saturation and clear priority.
        clr_cnt = 1'b1;
        idle(1);
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            m = rand_mask(1);
            send(encode(d) ^ m, predict(d, m));
        end
        idle(4);
        chk("sat_cnt_b", b_cnt_cor, 3);
        chk("sat_cnt_a", a_cnt_cor, 5);
        d = 8'h77;
        m = 13'h0100;
        send(encode(d) ^ m, predict(d, m));
        @(posedge clk);
        #1;
        chk("clr_hs_valid", a_out_valid, 1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_win_a", a_cnt_cor, 0);
        chk("clr_win_b", b_cnt_cor, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            d = 8'($urandom);
            m = rand_mask($urandom_range(0, 9) < 3 ? 0 :
                          $urandom_range(1, 3));
            in_code = encode(d) ^ m;
            cur_exp = predict(d, m);
            in_valid = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < 7;
            clr_cnt = $urandom_range(0, 99) == 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        clr_cnt = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("rand_drained", q.size(), 0);

        // Reset with both stages full.
        out_ready = 1'b0;
        send(encode(8'h11) ^ 13'h0004, predict(8'h11, 13'h0004));
        send(encode(8'h22) ^ 13'h0030, predict(8'h22, 13'h0030));
        chk("pre_rst_cnt_nz", (a_cnt_cor != 0) || (a_cnt_unc != 0), 1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", a_out_valid, 0);
        chk("arst_cnt_a", {a_cnt_cor, a_cnt_unc}, 0);
        chk("arst_cnt_b", {b_cnt_cor, b_cnt_unc}, 0);
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(6);
        chk("post_rst_valid", a_out_valid, 0);
        chk("post_rst_cnt", a_cnt_cor, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
